// File: rtl/router_pkg.sv
// Shared state encoding and sizing helpers for the multi-PE weight router.
// Used by router_weight_mc and router_rd_track.
package router_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      REQ   = ST_REQ,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } state_e;

   function automatic int unsigned kk_of(input int unsigned ks);
      return ks * ks;
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 32; i++) c += {31'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/router_rd_track.sv
// One-deep tracker: carries the destination strobe and spad address of a
// granted GLB read so they line up with the data returned a cycle later.
module router_rd_track
   import router_pkg::*;
#(
   parameter int NUM_PE = 3,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fire_i,
   input  logic [NUM_PE-1:0] en_i,
   input  logic [AW-1:0]     addr_i,
   output logic              vld_o,
   output logic [NUM_PE-1:0] en_o,
   output logic [AW-1:0]     addr_o
);

   logic              vld_q;
   logic [NUM_PE-1:0] en_q;
   logic [AW-1:0]     addr_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_q  <= 1'b0;
         en_q   <= '0;
         addr_q <= '0;
      end else begin
         vld_q <= fire_i;
         if (fire_i) begin
            en_q   <= en_i;
            addr_q <= addr_i;
         end
      end
   end

   assign vld_o  = vld_q;
   assign en_o   = en_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/router_weight_mc.sv
// Multi-PE weight router: streams GLB weight blocks into PE scratchpads.
// Optional ROUTER_WEIGHT_MC_STALL_CNT_EN adds a 16-bit grant-stall counter.
module router_weight_mc
   import router_pkg::*;
#(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int ADDR_BITWIDTH_SPAD = 9,
   parameter int NUM_PE            = 3,
   parameter int KERNEL_SIZE       = 3,
   parameter int MAX_FILT          = 4,
   localparam int CNT_W            = $clog2(MAX_FILT + 1)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [ADDR_BITWIDTH_GLB-1:0]  base_addr,
   input  logic [CNT_W-1:0]              num_filt,
   input  logic [NUM_PE-1:0]             pe_mask,
   input  logic                          bcast,
   output logic                          busy,
   output logic                          done,
   output logic                          read_req_glb_wght,
   output logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_glb_wght,
   input  logic                          glb_gnt,
   input  logic [DATA_BITWIDTH-1:0]      r_data_glb_wght,
   output logic [DATA_BITWIDTH-1:0]      w_data_spad,
   output logic [ADDR_BITWIDTH_SPAD-1:0] w_addr_spad,
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
   output logic [15:0]                   stall_cycles,
`endif
   output logic [NUM_PE-1:0]             load_en_spad
);

   localparam int KK   = kk_of(KERNEL_SIZE);
   localparam int TMAX = MAX_FILT * KK * NUM_PE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = ADDR_BITWIDTH_SPAD;
   localparam int PW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   state_e                        state_q;
   logic                          busy_q, done_q, req_q;
   logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_q;
   logic [NUM_PE-1:0]             mask_q;
   logic                          bcast_q;
   logic [SW-1:0]                 n_q, wcnt_q;
   logic [TW-1:0]                 tot_q, rd_cnt_q;
   logic [PW-1:0]                 pe_q;
   logic [NUM_PE-1:0]             load_q;
   logic [DATA_BITWIDTH-1:0]      wdata_q;
   logic [SW-1:0]                 waddr_q;

   logic [SW-1:0]                 n_d;
   logic [TW-1:0]                 tot_d;
   logic [PW-1:0]                 first_pe_d, next_pe_d;
   logic [NUM_PE-1:0]             dst;
   logic                          fire;
   logic                          trk_vld;
   logic [NUM_PE-1:0]             trk_en;
   logic [SW-1:0]                 trk_addr;

   always_comb begin
      int unsigned nf;
      nf = 32'(num_filt);
      if (nf > unsigned'(MAX_FILT)) nf = unsigned'(MAX_FILT);
      n_d   = SW'(nf * KK);
      tot_d = bcast ? TW'(nf * KK)
                    : TW'(nf * KK * popcount(32'(pe_mask)));
   end

   // lowest enabled PE at start, and lowest enabled PE above the current one
   always_comb begin
      first_pe_d = '0;
      next_pe_d  = pe_q;
      for (int i = NUM_PE - 1; i >= 0; i--) begin
         if (pe_mask[i]) first_pe_d = PW'(i);
         if (mask_q[i] && PW'(i) > pe_q) next_pe_d = PW'(i);
      end
   end

   assign fire = req_q && glb_gnt;
   assign dst  = bcast_q ? mask_q : (NUM_PE'(1) << pe_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         req_q    <= 1'b0;
         r_addr_q <= '0;
         mask_q   <= '0;
         bcast_q  <= 1'b0;
         n_q      <= '0;
         tot_q    <= '0;
         rd_cnt_q <= '0;
         wcnt_q   <= '0;
         pe_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mask_q   <= pe_mask;
                  bcast_q  <= bcast;
                  n_q      <= n_d;
                  tot_q    <= tot_d;
                  busy_q   <= 1'b1;
                  r_addr_q <= base_addr;
                  rd_cnt_q <= '0;
                  wcnt_q   <= '0;
                  pe_q     <= first_pe_d;
                  if (n_d == '0 || pe_mask == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (fire) begin
                  r_addr_q <= r_addr_q + 1'b1;
                  rd_cnt_q <= rd_cnt_q + 1'b1;
                  if (wcnt_q == n_q - 1'b1) begin
                     wcnt_q <= '0;
                     pe_q   <= next_pe_d;
                  end else begin
                     wcnt_q <= wcnt_q + 1'b1;
                  end
                  if (rd_cnt_q == tot_q - 1'b1) begin
                     req_q   <= 1'b0;
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!trk_vld) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   router_rd_track #(
      .NUM_PE (NUM_PE),
      .AW     (SW)
   ) u_trk (
      .clk     (clk),
      .reset_n (reset_n),
      .fire_i  (fire),
      .en_i    (dst),
      .addr_i  (wcnt_q),
      .vld_o   (trk_vld),
      .en_o    (trk_en),
      .addr_o  (trk_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         load_q  <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
      end else begin
         load_q <= trk_vld ? trk_en : '0;
         if (trk_vld) begin
            wdata_q <= r_data_glb_wght;
            waddr_q <= trk_addr;
         end
      end
   end

`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         stall_q <= '0;
      else if (state_q == IDLE && start)
         stall_q <= '0;
      else if (state_q == REQ && req_q && !glb_gnt && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cycles = stall_q;
`endif

   assign busy              = busy_q;
   assign done              = done_q;
   assign read_req_glb_wght = req_q;
   assign r_addr_glb_wght   = r_addr_q;
   assign load_en_spad      = load_q;
   assign w_data_spad       = wdata_q;
   assign w_addr_spad       = waddr_q;

endmodule

// File: tb/tb_router_weight_mc.sv
// Self-checking bench for router_weight_mc against a queue-based model.
// Honours ROUTER_WEIGHT_MC_STALL_CNT_EN when the RTL is built with it.
module tb_router_weight_mc;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [9:0]  base_addr;
   logic [2:0]  num_filt;
   logic [2:0]  pe_mask;
   logic        bcast;
   logic        busy, done;
   logic        read_req_glb_wght;
   logic [9:0]  r_addr_glb_wght;
   logic        glb_gnt;
   logic [15:0] r_data_glb_wght;
   logic [15:0] w_data_spad;
   logic [8:0]  w_addr_spad;
   logic [2:0]  load_en_spad;
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   int nvec = 0;
   int nerr = 0;

   logic [9:0]  exp_rd[$];
   logic [31:0] exp_wr[$];
   int          exp_r;

   always #5 clk = ~clk;

   router_weight_mc dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .base_addr         (base_addr),
      .num_filt          (num_filt),
      .pe_mask           (pe_mask),
      .bcast             (bcast),
      .busy              (busy),
      .done              (done),
      .read_req_glb_wght (read_req_glb_wght),
      .r_addr_glb_wght   (r_addr_glb_wght),
      .glb_gnt           (glb_gnt),
      .r_data_glb_wght   (r_data_glb_wght),
      .w_data_spad       (w_data_spad),
      .w_addr_spad       (w_addr_spad),
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
      .stall_cycles      (stall_cycles),
`endif
      .load_en_spad      (load_en_spad)
   );

   function automatic logic [15:0] gdat(input logic [9:0] a);
      return (16'(a) * 16'd40503) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // GLB model: data for a granted address appears one cycle later
   task automatic tick();
      logic       f;
      logic [9:0] fa;
      f  = read_req_glb_wght && glb_gnt;
      fa = r_addr_glb_wght;
      @(posedge clk);
      #1;
      r_data_glb_wght = f ? gdat(fa) : 16'($urandom);
   endtask

   task automatic build(input logic [9:0] base, input int nf,
                        input logic [2:0] mask, input logic bc);
      int         n;
      logic [9:0] a;
      logic [8:0] k9;
      n = (nf > 4 ? 4 : nf) * 9;
      a = base;
      exp_rd.delete();
      exp_wr.delete();
      if (mask != 0) begin
         if (bc) begin
            for (int k = 0; k < n; k++) begin
               k9 = 9'(k);
               exp_rd.push_back(a);
               exp_wr.push_back({4'd0, mask, k9, gdat(a)});
               a = a + 10'd1;
            end
         end else begin
            for (int p = 0; p < 3; p++) begin
               if (mask[p]) begin
                  for (int k = 0; k < n; k++) begin
                     k9 = 9'(k);
                     exp_rd.push_back(a);
                     exp_wr.push_back({4'd0, 3'(1 << p), k9, gdat(a)});
                     a = a + 10'd1;
                  end
               end
            end
         end
      end
      exp_r = exp_rd.size();
   endtask

   task automatic run(input logic [9:0] base, input int nf,
                      input logic [2:0] mask, input logic bc, input int mode);
      int cyc, dcyc, stalls;
      bit seen;
      build(base, nf, mask, bc);
      base_addr = base;
      num_filt  = 3'(nf);
      pe_mask   = mask;
      bcast     = bc;
      start     = 1'b1;
      glb_gnt   = 1'b1;
      tick();
      start  = 1'b0;
      cyc    = 1;
      dcyc   = -1;
      stalls = 0;
      seen   = 0;
      while (cyc < 1000 && !seen) begin
         if (load_en_spad != 0) begin
            if (exp_wr.size() == 0)
               chk("wr_extra", 32'(load_en_spad), 0);
            else
               chk("wr", {4'd0, load_en_spad, w_addr_spad, w_data_spad},
                   exp_wr.pop_front());
         end
         chk("busy", 32'(busy), 1);
         if (done) begin
            seen = 1;
            dcyc = cyc;
         end else begin
            case (mode)
               0: glb_gnt = 1'b1;
               1: glb_gnt = cyc[0];
               default: glb_gnt = ($urandom_range(0, 3) != 0);
            endcase
            if (read_req_glb_wght) begin
               if (!glb_gnt)
                  stalls++;
               else if (exp_rd.size() == 0)
                  chk("rd_extra", 32'(read_req_glb_wght), 0);
               else
                  chk("rd_addr", 32'(r_addr_glb_wght), 32'(exp_rd.pop_front()));
            end
            if (cyc == 5) begin
               start     = 1'b1;
               base_addr = 10'($urandom);
               num_filt  = 3'($urandom);
               pe_mask   = 3'($urandom);
               bcast     = 1'($urandom);
            end
            tick();
            start = 1'b0;
            cyc++;
         end
      end
      if (!seen) chk("timeout", 32'(done), 1);
      chk("wr_left", exp_wr.size(), 0);
      chk("rd_left", exp_rd.size(), 0);
      if (mode == 0) chk("done_cyc", dcyc, exp_r == 0 ? 1 : 3 + exp_r);
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
      chk("stall", 32'(stall_cycles), stalls);
      if (mode == 1 && exp_r == 9) chk("stall8", 32'(stall_cycles), 8);
`endif
      tick();
      chk("post_done", {30'd0, busy, done}, 0);
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
      chk("stall_hold", 32'(stall_cycles), stalls);
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {busy, done, read_req_glb_wght, load_en_spad}, 0);
      chk(tag, {12'd0, r_addr_glb_wght, w_addr_spad}, 0);
      chk(tag, 32'(w_data_spad), 0);
`ifdef ROUTER_WEIGHT_MC_STALL_CNT_EN
      chk(tag, 32'(stall_cycles), 0);
`endif
   endtask

   initial begin
      reset_n         = 1'b0;
      start           = 1'b0;
      base_addr       = '0;
      num_filt        = '0;
      pe_mask         = '0;
      bcast           = 1'b0;
      glb_gnt         = 1'b0;
      r_data_glb_wght = '0;
      tick();
      tick();
      chk_zero("reset");
      reset_n = 1'b1;
      tick();

      run(10'd10, 1, 3'b111, 1'b0, 0);
      run(10'd300, 2, 3'b101, 1'b1, 0);
      run(10'd200, 1, 3'b010, 1'b0, 1);
      run(10'd1020, 1, 3'b001, 1'b0, 0);
      run(10'd5, 1, 3'b000, 1'b0, 0);
      run(10'd5, 0, 3'b111, 1'b1, 0);
      run(10'd900, 7, 3'b011, 1'b0, 2);
      run(10'd17, 4, 3'b110, 1'b1, 1);

      base_addr = 10'd40;
      num_filt  = 3'd4;
      pe_mask   = 3'b111;
      bcast     = 1'b0;
      start     = 1'b1;
      glb_gnt   = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      glb_gnt = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      chk_zero("mid_reset");
      reset_n = 1'b1;
      glb_gnt = 1'b1;
      tick();
      run(10'd40, 1, 3'b011, 1'b0, 0);

      for (int t = 0; t < 12; t++)
         run(10'($urandom), int'($urandom_range(0, 7)), 3'($urandom),
             1'($urandom), int'($urandom_range(0, 2)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
